// File: rtl/ram_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bist_pkg
//  Description : Shared types and helpers for the single-port RAM BIST engine:
//                FSM state encoding, pattern codes and the pattern generator.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } bist_state_e;

    localparam logic PAT_ADDR = 1'b0;   // data = address
    localparam logic PAT_INV  = 1'b1;   // data = ~address

    // Pattern word for one address. The address is zero-extended to the word
    // width before the optional inversion, so ~addr fills the upper bits with 1s.
    // 'inv' flips the selected pattern (used on odd passes of a loop).
    function automatic logic [63:0] pat_word(input logic [63:0] addr,
                                             input logic        pat,
                                             input logic        inv,
                                             input int unsigned data_w);
        logic [63:0] w;
        w = ((pat == PAT_INV) ^ inv) ? ~addr : addr;
        if (data_w < 32'd64) begin
            w = w & ((64'd1 << data_w) - 64'd1);
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_1port_bist_ctrl_sp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram
//  Description : Inferred single-port block RAM, read-first, 1 or 2 cycle read
//                latency. The array itself is never reset; only the output
//                register(s) are, so read data is 0 straight after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sp_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd1_q;

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read-first: a write cycle returns the word previously stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_q <= '0;
        end else if (en_i) begin
            rd1_q <= mem_q[addr_i];
        end
    end

    if (RD_LAT == 2) begin : g_out_reg
        logic [DATA_W-1:0] rd2_q;

        // Optional output register adding one cycle of latency.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd2_q <= '0;
            end else begin
                rd2_q <= rd1_q;
            end
        end

        assign rdata_o = rd2_q;
    end else begin : g_no_out_reg
        assign rdata_o = rd1_q;
    end

endmodule
`default_nettype wire

// File: rtl/ram_1port_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_1port_bist_ctrl
//  Description : Write/read-back self-test engine for a single-port RAM.
//                Each pass fills every address with a pattern, reads it all
//                back through a latency-matched check pipeline and reports
//                sticky error status plus a pass counter.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_1port_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic              pat_sel,
    input  logic              inj_en,
    input  logic [ADDR_W-1:0] inj_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [7:0]        pass_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    // ---------------------------------------------------------------- FSM state
    bist_state_e       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        drain_cnt_q;
    logic              pat_q;
    logic              inv_q;
    logic              inj_en_q;
    logic [ADDR_W-1:0] inj_addr_q;
    logic              loop_pend_q;   // next pass begins from IDLE on the done cycle
    logic              busy_q;
    logic              done_q;
    logic [7:0]        pass_cnt_q;

    // -------------------------------------------------------- check pipeline
    logic [RD_LAT-1:0] pv_q;
    logic [DATA_W-1:0] pexp_q  [RD_LAT];
    logic [ADDR_W-1:0] paddr_q [RD_LAT];

    // ---------------------------------------------------------- status regs
    logic              err_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [ADDR_W-1:0] first_err_addr_q;

    // ------------------------------------------------------------ RAM side
    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] exp_word;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              start_acc;
    logic              mismatch;

    // A user start is only taken from a genuinely idle engine; a pending loop
    // restart owns the IDLE cycle and abort always wins.
    assign start_acc = (state_q == ST_IDLE) && start && !abort && !loop_pend_q;
    assign mismatch  = pv_q[RD_LAT-1] && (ram_rdata != pexp_q[RD_LAT-1]);

    // Pattern generation and RAM command decode for the current address.
    always_comb begin
        ram_en    = (state_q == ST_WRITE) || (state_q == ST_READ);
        ram_we    = (state_q == ST_WRITE);
        exp_word  = DATA_W'(pat_word(64'(addr_q), pat_q, inv_q, 32'(DATA_W)));
        ram_wdata = exp_word;
        if (inj_en_q && (addr_q == inj_addr_q)) begin
            ram_wdata[0] = ~exp_word[0];
        end
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (addr_q),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Sequencer: address sweep, pass bookkeeping, busy/done outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            drain_cnt_q <= '0;
            pat_q       <= PAT_ADDR;
            inv_q       <= 1'b0;
            inj_en_q    <= 1'b0;
            inj_addr_q  <= '0;
            loop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q     <= ST_IDLE;
                addr_q      <= '0;
                drain_cnt_q <= '0;
                loop_pend_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (loop_pend_q || start) begin
                            state_q     <= ST_WRITE;
                            busy_q      <= 1'b1;
                            addr_q      <= '0;
                            loop_pend_q <= 1'b0;
                            pat_q       <= pat_sel;
                            inj_en_q    <= inj_en;
                            inj_addr_q  <= inj_addr;
                            if (loop_pend_q) begin
                                // Odd pass count inverts the pattern.
                                inv_q <= pass_cnt_q[0];
                            end else begin
                                inv_q      <= 1'b0;
                                pass_cnt_q <= '0;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (addr_q == ADDR_LAST) begin
                            addr_q  <= '0;
                            state_q <= ST_READ;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                    ST_READ: begin
                        if (addr_q == ADDR_LAST) begin
                            addr_q      <= '0;
                            drain_cnt_q <= '0;
                            state_q     <= ST_DRAIN;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt_q == DRAIN_LAST) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            pass_cnt_q  <= pass_cnt_q + 8'd1;
                            loop_pend_q <= loop_en;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 2'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Expected word and address ride alongside the RAM read latency.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pexp_q[i]  <= '0;
                paddr_q[i] <= '0;
            end
        end else if (abort) begin
            pv_q <= '0;
        end else begin
            pv_q[0]    <= (state_q == ST_READ);
            pexp_q[0]  <= exp_word;
            paddr_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]    <= pv_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
                paddr_q[i] <= paddr_q[i-1];
            end
        end
    end

    // Sticky error status; cleared by an accepted start, held across abort.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_q            <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
        end else if (start_acc) begin
            err_q            <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
        end else if (mismatch && !abort) begin
            err_q <= 1'b1;
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            if (!err_q) begin
                first_err_addr_q <= paddr_q[RD_LAT-1];
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign rd_data        = ram_rdata;
    assign rd_valid       = pv_q[RD_LAT-1];
    assign err            = err_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_addr_q;
    assign pass_cnt       = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_1port_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_1port_bist_ctrl
//  Description : Scoreboard bench for the RAM BIST engine. Two instances run
//                in parallel: (RD_LAT=1, CNT_W=16) and (RD_LAT=2, CNT_W=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_1port_bist_ctrl;

    localparam int DW  = 16;
    localparam int DEP = 32;
    localparam int AW  = 5;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int cyc; logic [15:0] data; int addr; } rd_e_t;
    typedef struct { int cyc; bit err; int cnt; int first; int pass; } dn_e_t;
    typedef struct { int lo; int hi; } win_t;

    function automatic void chk(input int cfg, input string nm,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h expected %0h (cycle %0d)", cfg, nm, act, exp, cyc);
        end
    endfunction

    // Pattern from its definition: address, or its bitwise complement.
    function automatic logic [15:0] ref_word(input int a, input bit inv);
        logic [15:0] w;
        w = 16'(a);
        if (inv) w = ~w;
        return w;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int LAT  = (gi == 0) ? 1 : 2;
        localparam int CW   = (gi == 0) ? 16 : 2;
        localparam int CMAX = (1 << CW) - 1;
        localparam int P    = 2 * DEP + LAT + 1;   // start-to-done distance

        logic          rst, start, abort, loop_en, pat_sel, inj_en;
        logic [AW-1:0] inj_addr;
        logic          busy, done, rd_valid, err;
        logic [DW-1:0] rd_data;
        logic [CW-1:0] err_cnt;
        logic [AW-1:0] first_err_addr;
        logic [7:0]    pass_cnt;
        bit            fin = 1'b0;

        rd_e_t rd_q[$];
        dn_e_t dn_q[$];
        win_t  win_q[$];
        bit    m_err;
        int    m_cnt, m_first, m_pc;

        ram_1port_bist_ctrl #(
            .DATA_W (DW), .DEPTH (DEP), .ADDR_W (AW), .RD_LAT (LAT), .CNT_W (CW)
        ) u_dut (
            .sys_clk (clk), .sys_rst (rst), .start (start), .abort (abort),
            .loop_en (loop_en), .pat_sel (pat_sel), .inj_en (inj_en),
            .inj_addr (inj_addr), .busy (busy), .done (done), .rd_data (rd_data),
            .rd_valid (rd_valid), .err (err), .err_cnt (err_cnt),
            .first_err_addr (first_err_addr), .pass_cnt (pass_cnt)
        );

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic model_clear();
            m_err = 1'b0; m_cnt = 0; m_first = 0; m_pc = 0;
        endtask

        // Predict n back-to-back passes whose start is sampled at cycle s.
        task automatic model_passes(input int s, input int n, input bit pat,
                                    input bit ie, input int ia);
            int st;
            st = s;
            for (int k = 0; k < n; k++) begin
                bit inv;
                inv = pat ^ m_pc[0];
                win_q.push_back('{st + 1, st + 2 * DEP + LAT});
                for (int a = 0; a < DEP; a++) begin
                    logic [15:0] w;
                    w = ref_word(a, inv);
                    if (ie && a == ia) begin
                        w[0] = ~w[0];
                        if (!m_err) m_first = a;
                        m_err = 1'b1;
                        if (m_cnt < CMAX) m_cnt++;
                    end
                    rd_q.push_back('{st + DEP + 1 + a + LAT, w, a});
                end
                m_pc = (m_pc + 1) % 256;
                dn_q.push_back('{st + P, m_err, m_cnt, m_first, m_pc});
                st += P;
            end
        endtask

        // Drop every expectation later than cycle x.
        task automatic purge_after(input int x);
            while (rd_q.size() > 0 && rd_q[rd_q.size()-1].cyc > x) void'(rd_q.pop_back());
            while (dn_q.size() > 0 && dn_q[dn_q.size()-1].cyc > x) void'(dn_q.pop_back());
            while (win_q.size() > 0 && win_q[win_q.size()-1].lo > x) void'(win_q.pop_back());
            if (win_q.size() > 0 && win_q[win_q.size()-1].hi > x) win_q[win_q.size()-1].hi = x;
        endtask

        task automatic chk_zero(input string tag);
            chk(gi, {tag, ".busy"}, busy, 0);
            chk(gi, {tag, ".done"}, done, 0);
            chk(gi, {tag, ".rd_valid"}, rd_valid, 0);
            chk(gi, {tag, ".rd_data"}, rd_data, 0);
            chk(gi, {tag, ".err"}, err, 0);
            chk(gi, {tag, ".err_cnt"}, err_cnt, 0);
            chk(gi, {tag, ".first_err_addr"}, first_err_addr, 0);
            chk(gi, {tag, ".pass_cnt"}, pass_cnt, 0);
        endtask

        // n passes; with noise, start and the latched controls toggle mid-pass.
        task automatic run(input int n, input bit pat, input bit ie, input int ia,
                           input bit noise);
            int s;
            pat_sel = pat; inj_en = ie; inj_addr = AW'(ia); loop_en = (n > 1);
            s = cyc;
            start = 1'b1;
            model_clear();
            model_passes(s, n, pat, ie, ia);
            tick();
            start = 1'b0;
            while (cyc < s + n * P + 1) begin
                if (cyc == s + (n - 1) * P + 1) loop_en = 1'b0;
                if (noise && n == 1 && cyc <= s + 2 * DEP + LAT) begin
                    start    = 1'($urandom_range(0, 1));
                    pat_sel  = 1'($urandom_range(0, 1));
                    inj_en   = 1'($urandom_range(0, 1));
                    inj_addr = AW'($urandom_range(0, DEP - 1));
                end else begin
                    start = 1'b0;
                end
                tick();
            end
            start = 1'b0;
        endtask

        // Loop, abort during the READ phase of the third pass.
        task automatic abort_run(input bit pat);
            int s, x;
            pat_sel = pat; inj_en = 1'b0; inj_addr = '0; loop_en = 1'b1;
            s = cyc;
            start = 1'b1;
            model_clear();
            model_passes(s, 3, pat, 1'b0, 0);
            tick();
            start = 1'b0;
            x = s + 2 * P + DEP + 1 + 10;
            while (cyc < x) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0; loop_en = 1'b0;
            purge_after(x);
            m_pc = 2;
            chk(gi, "abort.busy", busy, 0);
            chk(gi, "abort.rd_valid", rd_valid, 0);
            chk(gi, "abort.pass_cnt", pass_cnt, m_pc);
            repeat (P + 5) tick();
            start = 1'b1; abort = 1'b1;
            tick();
            start = 1'b0; abort = 1'b0;
            chk(gi, "start_abort.busy", busy, 0);
            chk(gi, "start_abort.pass_cnt", pass_cnt, m_pc);
            tick();
        endtask

        // Error from pass 1 of a loop, then reset in the WRITE phase of pass 2.
        task automatic reset_run();
            int s;
            pat_sel = 1'($urandom_range(0, 1)); inj_en = 1'b1; inj_addr = AW'(9);
            loop_en = 1'b1;
            s = cyc;
            start = 1'b1;
            model_clear();
            model_passes(s, 2, pat_sel, 1'b1, 9);
            tick();
            start = 1'b0;
            while (cyc < s + P + 10) tick();
            chk(gi, "pre_reset.err", err, 1);
            #1;
            rst = 1'b1;
            rd_q.delete(); dn_q.delete(); win_q.delete();
            model_clear();
            #1;
            chk_zero("async_reset");
            loop_en = 1'b0;
            tick(); tick();
            rst = 1'b0;
            tick();
            run(1, 1'b0, 1'b0, 0, 1'b0);
        endtask

        // Monitor: pops expectations when the DUT presents a word or a done.
        always @(negedge clk) begin
            if (!rst) begin
                bit bexp;
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                    chk(gi, "rd_valid", rd_valid, 1);
                    chk(gi, $sformatf("rd_data[a=%0d]", rd_q[0].addr), rd_data, rd_q[0].data);
                    void'(rd_q.pop_front());
                end else begin
                    chk(gi, "rd_valid_quiet", rd_valid, 0);
                end
                if (dn_q.size() > 0 && dn_q[0].cyc == cyc) begin
                    chk(gi, "done", done, 1);
                    chk(gi, "err", err, dn_q[0].err);
                    chk(gi, "err_cnt", err_cnt, dn_q[0].cnt);
                    chk(gi, "first_err_addr", first_err_addr, dn_q[0].first);
                    chk(gi, "pass_cnt", pass_cnt, dn_q[0].pass);
                    void'(dn_q.pop_front());
                end else begin
                    chk(gi, "done_quiet", done, 0);
                end
                while (win_q.size() > 0 && win_q[0].hi < cyc) void'(win_q.pop_front());
                bexp = (win_q.size() > 0 && win_q[0].lo <= cyc && cyc <= win_q[0].hi);
                chk(gi, "busy", busy, bexp);
            end
        end

        initial begin
            rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
            pat_sel = 1'b0; inj_en = 1'b0; inj_addr = '0;
            repeat (3) tick();
            chk_zero("reset");
            rst = 1'b0;
            tick(); tick();
            run(1, 1'b0, 1'b0, 0, 1'b0);     // plain address pattern
            tick();
            run(1, 1'b0, 1'b1, 5, 1'b0);     // single injected fault at 5
            tick();
            run(1, 1'b1, 1'b0, 0, 1'b0);     // inverted pattern
            tick();
            abort_run(1'b0);
            run(5, 1'b0, 1'b1, 7, 1'b0);     // looping with a fault every pass
            tick();
            reset_run();
            for (int r = 0; r < 6; r++) begin
                int n;
                n = $urandom_range(1, 3);
                repeat ($urandom_range(0, 3)) tick();
                run(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, DEP - 1), n == 1);
            end
            repeat (5) tick();
            chk(gi, "rd_q_left", rd_q.size(), 0);
            chk(gi, "dn_q_left", dn_q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
            checks++;
            errors++;
            $display("FAIL timeout: got unfinished after %0d cycles expected both configs finished", t);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
